// File: rtl/sample_repeater_if.sv
// sample_repeater_if: AXI-Stream beat bundle (data, last, valid/ready)
interface sample_repeater_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] tdata;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master (output tdata, tlast, tvalid, input tready);
  modport slave (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/sample_repeater.sv
// sample_repeater: emits each accepted AXI-Stream word R times, with a per-beat repetition index
module sample_repeater #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 4,
  parameter int LAST_EVERY = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [CNT_W-1:0] cfg_repeat,
  sample_repeater_if.slave in_s,
  sample_repeater_if.master out_m,
  output logic [CNT_W-1:0] out_rep_idx
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic last_q, last_d;
  logic [CNT_W-1:0] rep_q, rep_d, cnt_q, cnt_d;
  logic final_beat, in_xfer, out_xfer;
  assign final_beat = cnt_q == rep_q - CNT_W'(1);
  // Accepting on the final consumed beat gives back-to-back words with no bubble
  assign in_s.tready = reset_n && (state_q == EMPTY || (out_m.tready && final_beat));
  assign in_xfer = in_s.tvalid && in_s.tready;
  assign out_xfer = out_m.tvalid && out_m.tready;
  assign out_m.tvalid = state_q == FULL;
  assign out_m.tdata = data_q;
  assign out_m.tlast = state_q == FULL && last_q && (LAST_EVERY != 0 || final_beat);
  assign out_rep_idx = cnt_q;
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    last_d = last_q;
    rep_d = rep_q;
    cnt_d = cnt_q;
    if (in_xfer) begin
      state_d = FULL;
      data_d = in_s.tdata;
      last_d = in_s.tlast;
      rep_d = cfg_repeat == '0 ? CNT_W'(1) : cfg_repeat;
      cnt_d = '0;
    end else if (out_xfer) begin
      state_d = final_beat ? EMPTY : FULL;
      cnt_d = final_beat ? '0 : cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      data_q <= '0;
      last_q <= 1'b0;
      rep_q <= CNT_W'(1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      last_q <= last_d;
      rep_q <= rep_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_sample_repeater.sv
// tb_sample_repeater: directed plus random checks of two repeater variants against a beat-queue model
module tb_sample_repeater;
  typedef struct {
    logic [31:0] d;
    logic l;
    logic [3:0] idx;
    logic fin;
  } beat_t;
  logic clk, reset_n, in_last, in_valid, out_ready;
  logic [31:0] in_data;
  logic [3:0] cfg, idx0, idx1;
  int checks = 0, failures = 0, beats = 0, last0 = 0, last1 = 0, r, b, l0, l1;
  bit busy_e, rdy_e;
  beat_t q[$];
  sample_repeater_if #(.DATA_W(32)) i0 ();
  sample_repeater_if #(.DATA_W(32)) o0 ();
  sample_repeater_if #(.DATA_W(32)) i1 ();
  sample_repeater_if #(.DATA_W(32)) o1 ();
  assign i0.tdata = in_data;
  assign i0.tlast = in_last;
  assign i0.tvalid = in_valid;
  assign o0.tready = out_ready;
  assign i1.tdata = in_data;
  assign i1.tlast = in_last;
  assign i1.tvalid = in_valid;
  assign o1.tready = out_ready;
  sample_repeater #(.DATA_W(32), .CNT_W(4), .LAST_EVERY(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .cfg_repeat(cfg), .in_s(i0), .out_m(o0), .out_rep_idx(idx0));
  sample_repeater #(.DATA_W(32), .CNT_W(4), .LAST_EVERY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cfg_repeat(cfg), .in_s(i1), .out_m(o1), .out_rep_idx(idx1));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge reset_n) q.delete();
  // Inputs only change just after a rising edge, so the negedge sees what the next edge will use
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_valid", o0.tvalid, 0);
      chk("rst_data", o0.tdata, 0);
      chk("rst_idx", idx0, 0);
      chk("rst_last", o0.tlast, 0);
      chk("rst_ready", i0.tready, 0);
    end else begin
      busy_e = q.size() != 0;
      rdy_e = q.size() == 0 || (q.size() == 1 && out_ready);
      chk("valid", o0.tvalid, busy_e);
      chk("valid1", o1.tvalid, busy_e);
      chk("in_ready", i0.tready, rdy_e);
      chk("in_ready1", i1.tready, rdy_e);
      if (o0.tvalid && out_ready) begin
        beats++;
        last0 += o0.tlast;
        last1 += o1.tlast;
      end
      if (busy_e) begin
        chk("data", o0.tdata, q[0].d);
        chk("data1", o1.tdata, q[0].d);
        chk("rep_idx", idx0, q[0].idx);
        chk("rep_idx1", idx1, q[0].idx);
        chk("tlast_final", o0.tlast, q[0].l & q[0].fin);
        chk("tlast_every", o1.tlast, q[0].l);
        if (out_ready) void'(q.pop_front());
      end else begin
        chk("tlast_idle", o0.tlast, 0);
      end
      if (in_valid && rdy_e) begin
        r = (cfg == 0) ? 1 : int'(cfg);
        for (int k = 0; k < r; k++) q.push_back(beat_t'{in_data, in_last, 4'(k), k == r - 1});
      end
    end
  end
  task automatic send(input logic [31:0] d, input logic l, input logic [3:0] rc);
    bit acc = 0;
    int n = 0;
    cfg = rc;
    in_data = d;
    in_last = l;
    in_valid = 1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = i0.tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", acc, 1);
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || o0.tvalid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", q.size() == 0 && !o0.tvalid, 1);
  endtask
  initial begin
    logic [3:0] pat;
    int w;
    pat = 4'b1001;
    reset_n = 0;
    cfg = 0;
    in_data = 0;
    in_last = 0;
    in_valid = 0;
    out_ready = 1;
    #1;
    chk("reset_valid", o0.tvalid, 0);
    chk("reset_ready", i0.tready, 0);
    chk("reset_idx", idx0, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    #1 chk("ready_after_rst", i0.tready, 1);
    b = beats;
    send(32'hA5A5A5A5, 0, 4);
    drain();
    chk("first_word_beats", beats - b, 4);
    chk("first_word_idle", o0.tvalid, 0);
    b = beats;
    send(1, 0, 3);
    send(2, 0, 3);
    send(3, 0, 3);
    drain();
    chk("b2b_beats", beats - b, 9);
    b = beats;
    w = 0;
    cfg = 2;
    for (int c = 0; c < 80 && (w < 3 || q.size() != 0); c++) begin
      out_ready = pat[c % 4];
      in_valid = w < 3;
      in_data = 32'h100 + w;
      @(negedge clk);
      if (in_valid && i0.tready) w++;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    out_ready = 1;
    drain();
    chk("bp_words", w, 3);
    chk("bp_beats", beats - b, 6);
    b = beats;
    l0 = last0;
    l1 = last1;
    send(32'h11, 1, 3);
    drain();
    chk("tlast_beats", beats - b, 3);
    chk("tlast_final_count", last0 - l0, 1);
    chk("tlast_every_count", last1 - l1, 3);
    b = beats;
    send(32'h22, 0, 0);
    drain();
    chk("cfg0_beats", beats - b, 1);
    b = beats;
    send(32'h33, 0, 15);
    drain();
    chk("cfg15_beats", beats - b, 15);
    b = beats;
    send(32'h44, 0, 4);
    send(32'h55, 0, 2);
    drain();
    chk("cfg_change_beats", beats - b, 6);
    b = beats;
    send(32'h66, 0, 4);
    repeat (3) @(posedge clk);
    #1 reset_n = 0;
    #1;
    chk("async_rst_valid", o0.tvalid, 0);
    chk("async_rst_idx", idx0, 0);
    chk("async_rst_data", o0.tdata, 0);
    @(posedge clk);
    #1 reset_n = 1;
    #1 chk("ready_after_rst2", i0.tready, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_beats", beats - b, 3);
    chk("mid_rst_idle", o0.tvalid, 0);
    b = beats;
    send(32'h77, 0, 2);
    drain();
    chk("post_rst_beats", beats - b, 2);
    for (int c = 0; c < 600; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom;
      in_last = 1'($urandom_range(0, 1));
      cfg = 4'($urandom_range(0, 15));
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    out_ready = 1;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
